// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: control-signal encodings, FSM state codes and the
// default watchdog limit.
package mem_arbiter_pkg;

  // Access size / extension (memory_type).
  localparam logic [3:0] MT_X  = 4'd0;
  localparam logic [3:0] MT_B  = 4'd1;
  localparam logic [3:0] MT_H  = 4'd2;
  localparam logic [3:0] MT_W  = 4'd3;
  localparam logic [3:0] MT_BU = 4'd5;
  localparam logic [3:0] MT_HU = 4'd6;

  // Access direction (memory_rw).
  localparam logic [1:0] M_X = 2'd0;
  localparam logic [1:0] M_R = 2'd1;
  localparam logic [1:0] M_W = 2'd2;

  // Arbiter FSM encoding.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusyF = 2'd1;
  localparam logic [1:0] StBusyD = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam int unsigned TimeoutDefault = 15;

  function automatic logic rw_valid(logic [1:0] rw);
    return (rw == M_R) || (rw == M_W);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication, load extraction with
// sign/zero extension, and the misalignment flag for one access.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [3:0]  mtype_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Anything that is not a byte or halfword type behaves as a full word.
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = (addr_lo_i != 2'b00);
    case (mtype_i)
      MT_B, MT_BU: begin
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{wdata_i[7:0]}};
        rdata_o      = {{24{(mtype_i == MT_B) & rbyte[7]}}, rbyte};
        misaligned_o = 1'b0;
      end
      MT_H, MT_HU: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{(mtype_i == MT_H) & rhalf[15]}}, rhalf};
        misaligned_o = addr_lo_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data side first.
// Define MEM_ARB_TIMEOUT_EN to build the mem_ready watchdog (limit TIMEOUT wait cycles).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_done_o,
  output logic        if_err_o,
  input  logic        dm_req_i,
  input  logic [31:0] dm_addr_i,
  input  logic [3:0]  dm_memory_type_i,
  input  logic [1:0]  dm_memory_rw_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_done_o,
  output logic        dm_err_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  logic [1:0]  state_q, state_d;
  logic [3:0]  type_q, type_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        if_done_q, if_done_d, if_err_q, if_err_d;
  logic        dm_done_q, dm_done_d, dm_err_q, dm_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic        dm_valid;
  logic [31:0] req_addr;
  logic [3:0]  al_type;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_misaligned;
  logic        finish, fin_err;
  logic [31:0] fin_rdata;

  assign dm_valid = dm_req_i && rw_valid(dm_memory_rw_i);
  assign req_addr = dm_valid ? dm_addr_i : if_addr_i;

  // In IDLE the aligner judges the live request; while busy it extends the latched access.
  always_comb begin
    al_type = type_q;
    al_addr = addr_lo_q;
    if (state_q == StIdle) begin
      al_type = dm_valid ? dm_memory_type_i : MT_W;
      al_addr = req_addr[1:0];
    end
  end

  mem_lane_align u_align (
    .mtype_i      (al_type),
    .addr_lo_i    (al_addr),
    .wdata_i      (dm_wdata_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_lo_d   = addr_lo_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = '0;
    dm_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = '0;
    finish      = 1'b0;
    fin_err     = 1'b0;
    fin_rdata   = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (dm_valid || if_req_i) begin
          if (al_misaligned) begin
            state_d   = StResp;
            dm_done_d = dm_valid;
            dm_err_d  = dm_valid;
            if_done_d = !dm_valid;
            if_err_d  = !dm_valid;
          end else begin
            state_d     = dm_valid ? StBusyD : StBusyF;
            type_d      = al_type;
            addr_lo_d   = al_addr;
            mem_en_d    = 1'b1;
            mem_we_d    = dm_valid && (dm_memory_rw_i == M_W);
            mem_be_d    = al_be;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = dm_valid ? al_wdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      StBusyF, StBusyD: begin
        if (mem_ready_i) begin
          finish    = 1'b1;
          fin_rdata = al_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (finish) begin
          state_d     = StResp;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == StBusyD) begin
            dm_done_d  = 1'b1;
            dm_err_d   = fin_err;
            dm_rdata_d = fin_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_err_d   = fin_err;
            if_rdata_d = fin_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      type_q      <= MT_X;
      addr_lo_q   <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_lo_q   <= addr_lo_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_done_q   <= dm_done_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign if_err_o    = if_err_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_err_o    = dm_err_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified memory between the instruction-fetch stage and the data-memory (load/store) stage of the pipeline. Takes the `memory_type` / `memory_rw` controls produced by decode, generates word-aligned memory cycles with byte enables, and returns aligned, sign- or zero-extended load data. Sequences one transaction at a time through a small FSM, with data-side priority and an optional timeout watchdog.

## Interface
- `TIMEOUT`, 15: maximum wait cycles for `mem_ready` before a transaction is aborted. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, level; held until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched word, valid only while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse for a fetch.
- `if_err` out 1: qualifies `if_done`; set for a misaligned address or a timeout.
- `dm_req` in 1: data request, level; held until `dm_done`.
- `dm_addr` in 32: data byte address.
- `dm_memory_type` in 4: access size and extension, using the `MT_*` encodings.
- `dm_memory_rw` in 2: access direction, `M_R`, `M_W` or `M_X`.
- `dm_wdata` in 32: store data; only the low byte or halfword is significant for `SB` / `SH`.
- `dm_rdata` out 32: extended load result, valid only while `dm_done`=1.
- `dm_done` out 1: one-cycle completion pulse for a data access.
- `dm_err` out 1: qualifies `dm_done`; set for a misaligned access or a timeout.
- `mem_en` out 1: memory cycle active.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: byte enables.
- `mem_addr` out 32: word-aligned address, i.e. `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: raw read word from memory.
- `mem_ready` in 1: memory completes the current cycle when sampled high.

## Operation
- FSM states: IDLE, BUSY_F, BUSY_D, RESP. Reset state is IDLE.
- **IDLE, request selection**
  - A data request is valid when `dm_req`=1 and `dm_memory_rw` is `M_R` or `M_W`. A data request with `M_X` is ignored.
  - Data has fixed priority over fetch. On simultaneous requests, data is granted; fetch waits.
- **IDLE, misaligned requests**
  - Misaligned cases: fetch with `addr[1:0]`≠0; `MT_H`/`MT_HU` with `addr[0]`=1; `MT_W` with `addr[1:0]`≠0.
  - A misaligned request skips memory: the FSM goes directly to RESP with err=1 and rdata=0.
- **IDLE, aligned requests**
  - An aligned request goes to BUSY_F or BUSY_D.
  - The request's address, type, rw and wdata are latched on that edge.
- **BUSY_F / BUSY_D**
  - `mem_*` outputs are driven from the latched values.
  - When `mem_ready`=1 at an edge, `mem_rdata` is captured (extended for data reads) and the FSM moves to RESP.
- **RESP**
  - Exactly one of `if_done` / `dm_done` pulses, with the matching err and rdata.
  - Requests are ignored in RESP; the FSM returns to IDLE unconditionally.
  - A requester still asserting req in the cycle after done starts a new transaction.
- **Byte enables** (`mem_be`):
  - `MT_B`/`MT_BU`: `4'b0001<<addr[1:0]`.
  - `MT_H`/`MT_HU`: `4'b0011<<{addr[1],1'b0}`.
  - `MT_W`: `4'b1111`.
  - Reads use the same byte enables.
- **Write data** (`mem_wdata`): a byte is replicated ×4; a halfword is replicated ×2; a word passes through.
- **Read data** (`dm_rdata`): the selected lane is shifted to bit 0.
  - `MT_B` / `MT_H`: sign-extended.
  - `MT_BU` / `MT_HU`: zero-extended.
- An unknown `MT_*` value with a valid rw is treated as `MT_W`.

## Timing
- Reset values (asynchronous): every output 0; FSM in IDLE; timeout counter 0. A reset mid-transaction abandons the transaction with no done pulse, and `mem_en` drops immediately.
- All outputs are registered. `mem_en` rises the cycle after acceptance and stays stable until `mem_ready` is sampled high.
- Aligned access, zero wait states:
  - Request seen in IDLE at cycle 0.
  - `mem_en`=1 in cycle 1; `mem_ready`=1 in cycle 1.
  - done in cycle 2; IDLE in cycle 3.
  - Each wait cycle adds 1.
- Misaligned access: done with err in cycle 1.
- Maximum throughput: one access per 3 cycles.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter increments each BUSY cycle while `mem_ready`=0.
  - On reaching `TIMEOUT`, the FSM goes to RESP with err=1 and rdata=0, and `mem_en` drops.
  - The counter clears on entry to BUSY.
- Undefined: BUSY waits indefinitely; no counter is built; err is raised only for misalignment.

## Structure
- `MT_*`, `M_*` and `REG_*` encodings come from the shared control-signal defines; they are not redefined here.
- The FSM state encoding and the default `TIMEOUT` go in the shared constants file.
- One sub-module, `mem_lane_align`, which is combinational:
  - Inputs: type, `addr[1:0]`, wdata, raw rdata.
  - Outputs: `be`, the replicated wdata, the extended rdata, and the misaligned flag.

## Test plan
- Fetch only, `if_addr`=0x100, `mem_rdata`=0x00500093, `mem_ready` high immediately → `mem_addr`=0x100, `mem_be`=4'hF, `if_done` in cycle 2 with `if_rdata`=0x00500093 and `if_err`=0.
- Simultaneous `if_req` and a `dm_req` `MT_W` read at 0x200 → the data access is served first (`dm_done` cycle 2); the fetch is accepted in cycle 3 and `if_done` follows in cycle 5.
- `SB` to 0x203 with `dm_wdata`=0x000000A5 → `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; `LB` from 0x203 with `mem_rdata`=0x80xxxxxx → `dm_rdata`=0xFFFFFF80; `LBU` from the same address → 0x00000080.
- `MT_H` read at 0x201 → no `mem_en`; `dm_done`=1 and `dm_err`=1 in cycle 1. `if_addr`=0x102 → `if_err`=1.
- With `MEM_ARB_TIMEOUT_EN` and `mem_ready` held 0 → `dm_done` with `dm_err`=1 after `TIMEOUT` wait cycles, then `mem_en`=0.
- Assert `rst_n`=0 in the middle of a 3-wait-state access → all outputs are 0 immediately; after release, no stale done pulse appears and the next request completes normally.
